// File: rtl/decomp_pl_scheduler_if.sv
// Handshake bundle between the pipeline-period scheduler and its
// frame producer / result consumer.
interface decomp_pl_scheduler_if;
    logic in_valid;   // input frame available on Hmatrix_i/Yarray_i
    logic in_ready;   // scheduler can accept a frame
    logic in_load;    // datapath input-register capture pulse
    logic out_valid;  // result on Rmat/Yarr/colorder is valid
    logic out_ready;  // consumer accepts the result

    // Producer/consumer side
    modport master (
        output in_valid,
        output out_ready,
        input  in_ready,
        input  in_load,
        input  out_valid
    );

    // Scheduler side
    modport slave (
        input  in_valid,
        input  out_ready,
        output in_ready,
        output in_load,
        output out_valid
    );
endinterface

// File: rtl/decomp_pl_scheduler.sv
// decomp_pl_scheduler: pipeline-period scheduler for the 8x8 QR/sorted
// decomposition datapath. Generates the clk_pl stage-advance strobe once per
// PL_CYCLES clocks, admits one frame per period, tracks stage occupancy and
// stalls the period at phase PL_CYCLES-2 while a finished result is unread
// or while en is low.
module decomp_pl_scheduler #(
    parameter int PL_CYCLES = 23,  // system clocks per pipeline period, >= 3
    parameter int PL_DEPTH  = 6,   // clk_pl-advanced stages, >= 2
    parameter int CNT_W     = 5    // phase width, 2**CNT_W >= PL_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst,        // asynchronous, active low
    input  logic                    en,
    decomp_pl_scheduler_if.slave    bus,
    output logic                    clk_pl,
    output logic [CNT_W-1:0]        phase,
    output logic [PL_DEPTH-1:0]     stage_vld,
    output logic                    busy,
    output logic [15:0]             frame_cnt
);

    // Stall point: the last phase at which the period may be held. The
    // following phase is the single low cycle of clk_pl.
    localparam logic [CNT_W-1:0] PH_STALL = CNT_W'(PL_CYCLES - 2);
    localparam logic [CNT_W-1:0] PH_LAST  = CNT_W'(PL_CYCLES - 1);

    logic pending;    // frame admitted this period, enters stage 0 on advance
    logic out_taken;  // result in the last stage has already been consumed

    logic at_stall;
    logic at_last;
    logic advance;
    logic out_vld;
    logic in_hs;
    logic out_hs;
    logic blocked;
    logic hold;

    // Control decode: handshakes, stall condition and advance-edge qualifier
    always_comb begin
        // NOTE: every signal gets a value before any condition so that no
        // path leaves it unassigned and no latch is inferred.
        at_stall = (phase == PH_STALL);
        at_last  = (phase == PH_LAST);
        // The edge that wraps the phase to 0 is the one where clk_pl rises,
        // so the occupancy shift happens in the phase==PL_CYCLES-1 cycle.
        advance  = at_last;
        out_vld  = stage_vld[PL_DEPTH-1] & ~out_taken;
        in_hs    = bus.in_valid & ~pending;
        out_hs   = out_vld & bus.out_ready;
        // An unread result blocks the period; a handshake in the stall-point
        // cycle releases it in that same cycle.
        blocked  = stage_vld[PL_DEPTH-1] & ~out_taken & ~bus.out_ready;
        hold     = at_stall & (~en | blocked);
    end

    assign bus.in_ready  = ~pending;
    assign bus.in_load   = in_hs;
    assign bus.out_valid = out_vld;
    assign busy          = pending | (|stage_vld);

    // Period timing: phase counter with stall point and registered strobe
    // NOTE: the reset is asynchronous and active low, so it sits in the
    // sensitivity list and is tested first; all other state follows the clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase  <= '0;
            clk_pl <= 1'b0;
        end else begin
            // NOTE: registered state uses non-blocking assignments so every
            // flop samples the pre-edge values of the others.
            if (hold) begin
                phase <= phase;
            end else if (at_last) begin
                phase <= '0;
            end else begin
                phase <= phase + CNT_W'(1);
            end
            // Low only in the cycle after an unheld stall point; while held
            // it stays high and the datapath sees no edge.
            clk_pl <= ~(at_stall & ~hold);
        end
    end

    // Admission and per-stage occupancy, shifted on the advance edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending   <= 1'b0;
            stage_vld <= '0;
        end else if (advance) begin
            stage_vld <= {stage_vld[PL_DEPTH-2:0], pending};
            // A frame accepted in the wrap cycle belongs to the next period.
            pending   <= in_hs;
        end else if (in_hs) begin
            pending   <= 1'b1;
        end
    end

    // Result delivery: consumed flag and completed-frame counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_taken <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (out_hs) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (advance) begin
                out_taken <= 1'b0;
            end else if (out_hs) begin
                out_taken <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_decomp_pl_scheduler.sv
// Self-checking bench for decomp_pl_scheduler. Admitted frames push their
// expected out_valid rise cycle into a scoreboard queue; the monitor pops and
// compares when the DUT raises out_valid. Directed checks cover reset, period
// timing, backpressure, en stall and reset mid-operation.
module tb_decomp_pl_scheduler;

    localparam int PL_CYCLES = 23;
    localparam int PL_DEPTH  = 6;
    localparam int CNT_W     = 5;

    logic                 clk;
    logic                 rst;
    logic                 en;
    logic                 clk_pl;
    logic [CNT_W-1:0]     phase;
    logic [PL_DEPTH-1:0]  stage_vld;
    logic                 busy;
    logic [15:0]          frame_cnt;

    decomp_pl_scheduler_if sif();

    decomp_pl_scheduler #(
        .PL_CYCLES (PL_CYCLES),
        .PL_DEPTH  (PL_DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .bus       (sif),
        .clk_pl    (clk_pl),
        .phase     (phase),
        .stage_vld (stage_vld),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;   // posedges seen so far; at a negedge it names the cycle
    int t0     = 0;   // cycle at which reset was released (phase 0)
    int n_loads = 0;
    bit chk_period = 0;
    bit prev_ov = 0;
    int sb[$];        // expected out_valid rise cycles, in admission order
    int mon_p;
    int mon_exp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc - t0);
        end
    endtask

    // Expected out_valid rise for a frame accepted at absolute cycle c,
    // assuming no stall since t0: the frame enters stage 0 at the next period
    // start (or the one after, if accepted in the wrap cycle), then needs
    // PL_DEPTH-1 further periods to reach the last stage.
    function automatic int exp_rise(input int c);
        int rel;
        int k;
        int p;
        rel = c - t0;
        k = rel / PL_CYCLES;
        p = rel % PL_CYCLES;
        return t0 + PL_CYCLES * (k + ((p == PL_CYCLES - 1) ? 2 : 1))
                  + (PL_DEPTH - 1) * PL_CYCLES;
    endfunction

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic do_reset();
        sif.in_valid  = 1'b0;
        sif.out_ready = 1'b1;
        en            = 1'b1;
        rst           = 1'b0;
        chk_period    = 0;
        sb.delete();
        n_loads       = 0;
        repeat (2) @(negedge clk);
        #4;
        check("rst_phase",     32'(phase), 0);
        check("rst_clk_pl",    32'(clk_pl), 0);
        check("rst_stage_vld", 32'(stage_vld), 0);
        check("rst_busy",      32'(busy), 0);
        check("rst_in_ready",  32'(sif.in_ready), 1);
        check("rst_in_load",   32'(sif.in_load), 0);
        check("rst_out_valid", 32'(sif.out_valid), 0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);
        @(negedge clk);
        rst = 1'b1;
        t0  = cyc;
    endtask

    // Monitor: scoreboard push/pop and unstalled period timing
    always @(negedge clk) begin
        #3;
        if (!rst) begin
            prev_ov = 0;
        end else begin
            if (sif.in_load) begin
                n_loads++;
                sb.push_back(exp_rise(cyc));
            end
            if (sif.out_valid && !prev_ov) begin
                if (sb.size() == 0) begin
                    check("out_spurious", 32'(sif.out_valid), 0);
                end else begin
                    mon_exp = sb.pop_front();
                    check("out_rise_cycle", cyc - t0, mon_exp - t0);
                end
            end
            prev_ov = sif.out_valid;
            if (chk_period) begin
                mon_p = (cyc - t0) % PL_CYCLES;
                check("period_phase", 32'(phase), mon_p);
                check("period_clk_pl", 32'(clk_pl),
                      (cyc == t0) ? 0 : ((mon_p != PL_CYCLES - 1) ? 1 : 0));
            end
        end
    end

    initial begin
        #60000;
        $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit low_seen;
        rst           = 1'b0;
        en            = 1'b1;
        sif.in_valid  = 1'b0;
        sif.out_ready = 1'b1;

        // Idle after reset: periodic strobe, nothing occupied
        do_reset();
        chk_period = 1;
        wait_to(t0 + 70);
        #4;
        check("idle_stage_vld", 32'(stage_vld), 0);
        check("idle_busy",      32'(busy), 0);
        check("idle_in_ready",  32'(sif.in_ready), 1);

        // Single frame at phase 0, stage bits walk, 1-cycle result pulse
        do_reset();
        chk_period = 1;
        wait_to(t0 + 23);
        sif.in_valid = 1'b1;
        wait_to(t0 + 24);
        sif.in_valid = 1'b0;
        for (int i = 0; i < PL_DEPTH; i++) begin
            wait_to(t0 + 46 + 23 * i);
            #4;
            check("walk_stage_vld", 32'(stage_vld), 32'(1) << i);
        end
        wait_to(t0 + 162);
        #4;
        check("single_pulse_end", 32'(sif.out_valid), 0);
        wait_to(t0 + 163);
        #4;
        check("single_frame_cnt", 32'(frame_cnt), 1);
        check("single_loads",     n_loads, 1);
        check("single_sb_empty",  sb.size(), 0);

        // in_valid held 200 cycles: one accept per period
        do_reset();
        chk_period = 1;
        wait_to(t0 + 23);
        sif.in_valid = 1'b1;
        wait_to(t0 + 24);
        #4;
        check("stream_ready_after_acc", 32'(sif.in_ready), 0);
        wait_to(t0 + 45);
        #4;
        check("stream_ready_wrap", 32'(sif.in_ready), 0);
        wait_to(t0 + 46);
        #4;
        check("stream_ready_new_period", 32'(sif.in_ready), 1);
        check("stream_load_new_period",  32'(sif.in_load), 1);
        wait_to(t0 + 223);
        sif.in_valid = 1'b0;
        wait_to(t0 + 350);
        #4;
        check("stream_loads",     n_loads, 9);
        check("stream_frame_cnt", 32'(frame_cnt), 9);
        check("stream_sb_empty",  sb.size(), 0);

        // Accept in the wrap cycle lands in stage 0 one period later
        do_reset();
        chk_period = 1;
        wait_to(t0 + 22);
        sif.in_valid = 1'b1;
        wait_to(t0 + 23);
        sif.in_valid = 1'b0;
        #4;
        check("wrap_acc_stage_vld0", 32'(stage_vld), 0);
        check("wrap_acc_busy",       32'(busy), 1);
        wait_to(t0 + 45);
        #4;
        check("wrap_acc_stage_vld1", 32'(stage_vld), 0);
        wait_to(t0 + 46);
        #4;
        check("wrap_acc_stage_vld2", 32'(stage_vld), 1);
        wait_to(t0 + 165);
        #4;
        check("wrap_acc_frame_cnt", 32'(frame_cnt), 1);
        check("wrap_acc_sb_empty",  sb.size(), 0);

        // Backpressure: result unread holds phase at the stall point
        do_reset();
        sif.out_ready = 1'b0;
        chk_period = 1;
        wait_to(t0 + 23);
        sif.in_valid = 1'b1;
        wait_to(t0 + 24);
        sif.in_valid = 1'b0;
        wait_to(t0 + 170);
        chk_period = 0;
        for (int c = 182; c < 192; c++) begin
            wait_to(t0 + c);
            #4;
            check("bp_phase",     32'(phase), PL_CYCLES - 2);
            check("bp_clk_pl",    32'(clk_pl), 1);
            check("bp_stage_vld", 32'(stage_vld), 32'h20);
            check("bp_out_valid", 32'(sif.out_valid), 1);
        end
        wait_to(t0 + 192);
        sif.out_ready = 1'b1;
        wait_to(t0 + 193);
        #4;
        check("bp_rel_phase",     32'(phase), PL_CYCLES - 1);
        check("bp_rel_clk_pl",    32'(clk_pl), 0);
        check("bp_rel_out_valid", 32'(sif.out_valid), 0);
        check("bp_rel_frame_cnt", 32'(frame_cnt), 1);
        wait_to(t0 + 194);
        #4;
        check("bp_adv_phase",     32'(phase), 0);
        check("bp_adv_clk_pl",    32'(clk_pl), 1);
        check("bp_adv_stage_vld", 32'(stage_vld), 0);
        check("bp_sb_empty",      sb.size(), 0);

        // en low for 40 cycles from phase 5
        do_reset();
        chk_period = 1;
        wait_to(t0 + 5);
        en = 1'b0;
        chk_period = 0;
        low_seen = 0;
        for (int c = 6; c < 45; c++) begin
            wait_to(t0 + c);
            #4;
            if (c >= 21) check("en_hold_phase", 32'(phase), PL_CYCLES - 2);
            low_seen |= ~clk_pl;
        end
        wait_to(t0 + 45);
        en = 1'b1;
        #4;
        check("en_last_hold_phase", 32'(phase), PL_CYCLES - 2);
        low_seen |= ~clk_pl;
        check("en_no_clk_pl_low", 32'(low_seen), 0);
        wait_to(t0 + 46);
        #4;
        check("en_rel_phase",  32'(phase), PL_CYCLES - 1);
        check("en_rel_clk_pl", 32'(clk_pl), 0);
        wait_to(t0 + 47);
        #4;
        check("en_wrap_phase",  32'(phase), 0);
        check("en_wrap_clk_pl", 32'(clk_pl), 1);

        // Reset with three frames in flight, then a fresh frame
        do_reset();
        chk_period = 1;
        wait_to(t0 + 1);
        sif.in_valid = 1'b1;
        wait_to(t0 + 50);
        sif.in_valid = 1'b0;
        wait_to(t0 + 60);
        chk_period = 0;
        #1;
        check("inflight_stage_vld", 32'(stage_vld), 3);
        check("inflight_busy",      32'(busy), 1);
        #1;
        rst = 1'b0;
        #1;
        check("arst_phase",     32'(phase), 0);
        check("arst_clk_pl",    32'(clk_pl), 0);
        check("arst_stage_vld", 32'(stage_vld), 0);
        check("arst_busy",      32'(busy), 0);
        check("arst_in_ready",  32'(sif.in_ready), 1);
        check("arst_out_valid", 32'(sif.out_valid), 0);
        do_reset();
        chk_period = 1;
        wait_to(t0 + 23);
        sif.in_valid = 1'b1;
        wait_to(t0 + 24);
        sif.in_valid = 1'b0;
        wait_to(t0 + 200);
        #4;
        check("post_rst_frame_cnt", 32'(frame_cnt), 1);
        check("post_rst_loads",     n_loads, 1);
        check("post_rst_sb_empty",  sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
